// File: rtl/t_counter_pkg.sv
// Shared constants for the toggle-stage up/down modulo counter.
package t_counter_pkg;

    localparam int   WIDTH_DEFAULT = 8;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;

endpackage

// File: rtl/t_ff.sv
// Single toggle stage: q inverts on a clock edge whenever t is high.
module t_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q,
    output logic q_bar
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q     = r_q;
    assign q_bar = ~r_q;

endmodule

// File: rtl/t_counter.sv
// Up/down modulo counter built from toggle stages; next state is computed
// here and turned into a per-bit toggle vector, tc flags a wrap on the prior edge.
module t_counter
    import t_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_t;
    logic             w_wrap;
    logic             r_tc;

    // A zero modulus selects the full binary range.
    assign w_last = (mod_val == '0) ? '1 : (mod_val - WIDTH'(1));

    always_comb begin
        w_next = w_q;
        w_wrap = 1'b0;
        if (load) begin
            w_next = load_val;
        end else if (enable) begin
            if (up == DIR_UP) begin
                if (w_q >= w_last) begin
                    w_next = '0;
                    w_wrap = 1'b1;
                end else begin
                    w_next = w_q + WIDTH'(1);
                end
            end else begin
                if (w_q == '0) begin
                    w_next = w_last;
                    w_wrap = 1'b1;
                end else begin
                    w_next = w_q - WIDTH'(1);
                end
            end
        end
    end

    assign w_t = w_q ^ w_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        t_ff u_t_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (w_t[i]),
            .q     (w_q[i]),
            .q_bar (w_q_bar[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_wrap;
        end
    end

    assign q     = w_q;
    assign q_bar = w_q_bar;
    assign tc    = r_tc;

endmodule

// File: tb/tb_t_counter.sv
// Directed bench for t_counter: arithmetic reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_t_counter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] mod_val;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic         tc;

    int total = 0;
    int bad   = 0;

    int m_q;
    int m_tc;

    t_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .mod_val  (mod_val),
        .q        (q),
        .q_bar    (q_bar),
        .tc       (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model straight from the counting rules.
    always @(posedge clk or negedge rst_n) begin
        int last;
        if (!rst_n) begin
            m_q  <= 0;
            m_tc <= 0;
        end else begin
            last = (mod_val == 0) ? ((1 << W) - 1) : (int'(mod_val) - 1);
            if (load) begin
                m_q  <= int'(load_val);
                m_tc <= 0;
            end else if (enable && up) begin
                if (m_q >= last) begin
                    m_q  <= 0;
                    m_tc <= 1;
                end else begin
                    m_q  <= m_q + 1;
                    m_tc <= 0;
                end
            end else if (enable) begin
                if (m_q == 0) begin
                    m_q  <= last;
                    m_tc <= 1;
                end else begin
                    m_q  <= m_q - 1;
                    m_tc <= 0;
                end
            end else begin
                m_tc <= 0;
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if (int'(q) != m_q || int'(q_bar) != (~m_q & ((1 << W) - 1)) || int'(tc) != m_tc) begin
            bad++;
            $display("FAIL model_cmp t=%0t: q=%0h q_bar=%0h tc=%0b, expected q=%0h q_bar=%0h tc=%0d",
                     $time, q, q_bar, tc, m_q, ~m_q & ((1 << W) - 1), m_tc);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Called at a falling edge; applies inputs and lets n rising edges pass.
    task automatic drive(input logic en, input logic u, input logic ld,
                         input logic [W-1:0] lv, input logic [W-1:0] mv, input int n);
        enable   = en;
        up       = u;
        load     = ld;
        load_val = lv;
        mod_val  = mv;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        mod_val  = '0;
        repeat (2) @(negedge clk);
        check("reset_q", int'(q), 0);
        check("reset_qbar", int'(q_bar), 8'hFF);
        check("reset_tc", int'(tc), 0);
        rst_n = 1'b1;

        // Full-range up count with wrap at 256.
        drive(1, 1, 0, 0, 0, 255);
        check("full_255_q", int'(q), 255);
        check("full_255_tc", int'(tc), 0);
        drive(1, 1, 0, 0, 0, 1);
        check("full_wrap_q", int'(q), 0);
        check("full_wrap_tc", int'(tc), 1);
        drive(1, 1, 0, 0, 0, 1);
        check("full_after_q", int'(q), 1);
        check("full_after_tc", int'(tc), 0);
        drive(1, 1, 0, 0, 0, 3);

        // Modulo 10 up, then reverse at 3.
        drive(0, 1, 1, 0, 10, 1);
        drive(1, 1, 0, 0, 10, 9);
        check("mod10_9_q", int'(q), 9);
        drive(1, 1, 0, 0, 10, 1);
        check("mod10_wrap_q", int'(q), 0);
        check("mod10_wrap_tc", int'(tc), 1);
        drive(1, 1, 0, 0, 10, 13);
        check("mod10_3_q", int'(q), 3);
        drive(1, 0, 0, 0, 10, 3);
        check("mod10_dn0_q", int'(q), 0);
        check("mod10_dn0_tc", int'(tc), 0);
        drive(1, 0, 0, 0, 10, 1);
        check("mod10_dnwrap_q", int'(q), 9);
        check("mod10_dnwrap_tc", int'(tc), 1);

        // Load beyond last; up wraps, down decrements.
        drive(1, 1, 1, 8'hC8, 100, 1);
        check("ld_c8_q", int'(q), 8'hC8);
        check("ld_c8_tc", int'(tc), 0);
        drive(1, 1, 0, 0, 100, 1);
        check("ld_c8_up_q", int'(q), 0);
        check("ld_c8_up_tc", int'(tc), 1);
        drive(1, 0, 1, 8'hC8, 100, 1);
        drive(1, 0, 0, 0, 100, 1);
        check("ld_c8_dn_q", int'(q), 8'hC7);

        // Hold.
        drive(0, 1, 1, 8'h42, 0, 1);
        drive(0, 1, 0, 0, 0, 5);
        check("hold_q", int'(q), 8'h42);
        check("hold_qbar", int'(q_bar), 8'hBD);
        check("hold_tc", int'(tc), 0);

        // Asynchronous reset between edges.
        drive(0, 1, 1, 8'h37, 0, 1);
        load = 1'b0;
        check("pre_rst_q", int'(q), 8'h37);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q", int'(q), 0);
        check("arst_qbar", int'(q_bar), 8'hFF);
        check("arst_tc", int'(tc), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 1);
        check("post_rst_q", int'(q), 1);

        // Modulus change takes effect immediately.
        drive(1, 1, 1, 3, 5, 1);
        drive(1, 1, 0, 0, 5, 1);
        check("modchg_4_q", int'(q), 4);
        drive(1, 1, 0, 0, 4, 1);
        check("modchg_wrap_q", int'(q), 0);
        check("modchg_wrap_tc", int'(tc), 1);

        // Modulus 1 in both directions.
        drive(0, 1, 1, 0, 1, 1);
        drive(1, 1, 0, 0, 1, 2);
        check("mod1_up_q", int'(q), 0);
        check("mod1_up_tc", int'(tc), 1);
        drive(1, 0, 0, 0, 1, 3);
        check("mod1_dn_q", int'(q), 0);
        check("mod1_dn_tc", int'(tc), 1);
        drive(0, 1, 0, 0, 1, 1);
        check("mod1_stop_tc", int'(tc), 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
